// File: rtl/lot_occupancy_ctrl_pkg.sv
// ============================================================================
// Module      : lot_occupancy_ctrl_pkg
// Description : Shared state/side encodings and default sizing for the
//               lot occupancy controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lot_occupancy_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_ENT = 2'd1,
        GRANT_EXT = 2'd2,
        WAIT_REL  = 2'd3
    } state_t;

    typedef enum logic {
        ENTER = 1'b0,
        EXIT  = 1'b1
    } side_t;

    localparam int unsigned c_DEF_CAPACITY = 7;
    localparam int unsigned c_DEF_CNT_W    = 3;

endpackage : lot_occupancy_ctrl_pkg

`default_nettype wire

// File: rtl/lot_occupancy_ctrl_if.sv
// ============================================================================
// Module      : lot_occupancy_ctrl_if
// Description : Requester/status bundle between the gates and the occupancy
//               controller. reject_count exists only with OCC_REJECT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lot_occupancy_ctrl_if #(
    parameter int unsigned CNT_W = 3
);
    logic             enter_req;
    logic             exit_req;
    logic             enter_grant;
    logic             exit_grant;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
`ifdef OCC_REJECT_CNT_EN
    logic [7:0]       reject_count;
`endif

    modport master (
        output enter_req, exit_req,
        input  enter_grant, exit_grant, count, full, empty
`ifdef OCC_REJECT_CNT_EN
        , input reject_count
`endif
    );

    modport slave (
        input  enter_req, exit_req,
        output enter_grant, exit_grant, count, full, empty
`ifdef OCC_REJECT_CNT_EN
        , output reject_count
`endif
    );

endinterface : lot_occupancy_ctrl_if

`default_nettype wire

// File: rtl/lot_occupancy_ctrl_occ_counter.sv
// ============================================================================
// Module      : occ_counter
// Description : CNT_W-bit up/down occupancy counter, saturating at 0 and
//               CAPACITY, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module occ_counter #(
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned CAPACITY = 7
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_dec,
    output logic      [CNT_W-1:0] o_count
);
    localparam logic [CNT_W-1:0] c_CAP = CNT_W'(CAPACITY);

    logic [CNT_W-1:0] r_count;

    // Simultaneous inc/dec cancels; guards keep the value inside 0..CAPACITY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count != c_CAP)) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : occ_counter

`default_nettype wire

// File: rtl/lot_occupancy_ctrl.sv
// ============================================================================
// Module      : lot_occupancy_ctrl
// Description : Round-robin arbiter/FSM granting entry/exit requests against
//               a shared occupancy counter. Option macro: OCC_REJECT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lot_occupancy_ctrl
    import lot_occupancy_ctrl_pkg::*;
#(
    parameter int unsigned CAPACITY = c_DEF_CAPACITY,
    parameter int unsigned CNT_W    = c_DEF_CNT_W
) (
    input wire logic              clk,
    input wire logic              rst,
    lot_occupancy_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] c_CAP = CNT_W'(CAPACITY);

    state_t           r_state,       w_next_state;
    side_t            r_owner,       w_next_owner;
    side_t            r_last_served, w_next_last;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_ent_elig;
    logic             w_ext_elig;
    logic             w_owner_req;

    assign w_full      = (w_count == c_CAP);
    assign w_empty     = (w_count == '0);
    assign w_ent_elig  = bus.enter_req & ~w_full;
    assign w_ext_elig  = bus.exit_req  & ~w_empty;
    assign w_owner_req = (r_owner == ENTER) ? bus.enter_req : bus.exit_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_owner       <= ENTER;
            r_last_served <= EXIT;
        end else begin
            r_state       <= w_next_state;
            r_owner       <= w_next_owner;
            r_last_served <= w_next_last;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last_served;
        case (r_state)
            IDLE: begin
                // Entry wins unless exit is also eligible and entry went last.
                if (w_ent_elig && (!w_ext_elig || (r_last_served == EXIT))) begin
                    w_next_state = GRANT_ENT;
                    w_next_owner = ENTER;
                    w_next_last  = ENTER;
                end else if (w_ext_elig) begin
                    w_next_state = GRANT_EXT;
                    w_next_owner = EXIT;
                    w_next_last  = EXIT;
                end else if (bus.enter_req) begin
                    w_next_state = WAIT_REL;
                    w_next_owner = ENTER;
                end else if (bus.exit_req) begin
                    w_next_state = WAIT_REL;
                    w_next_owner = EXIT;
                end
            end
            GRANT_ENT: w_next_state = WAIT_REL;
            GRANT_EXT: w_next_state = WAIT_REL;
            WAIT_REL: begin
                if (!w_owner_req) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    occ_counter #(
        .CNT_W    (CNT_W),
        .CAPACITY (CAPACITY)
    ) u_occ_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (bus.enter_grant),
        .i_dec   (bus.exit_grant),
        .o_count (w_count)
    );

    assign bus.enter_grant = (r_state == GRANT_ENT);
    assign bus.exit_grant  = (r_state == GRANT_EXT);
    assign bus.count       = w_count;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;

`ifdef OCC_REJECT_CNT_EN
    logic       w_refuse;
    logic [7:0] r_reject_count;

    // A refusal is the only path from IDLE straight into WAIT_REL.
    assign w_refuse = (r_state == IDLE) && (w_next_state == WAIT_REL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reject_count <= '0;
        end else if (w_refuse && (r_reject_count != 8'hFF)) begin
            r_reject_count <= r_reject_count + 8'd1;
        end
    end

    assign bus.reject_count = r_reject_count;
`endif

endmodule : lot_occupancy_ctrl

`default_nettype wire

// File: tb/tb_lot_occupancy_ctrl.sv
// ============================================================================
// Module      : tb_lot_occupancy_ctrl
// Description : Directed self-checking bench for lot_occupancy_ctrl
//               (CAPACITY=7, CNT_W=3); reject checks with OCC_REJECT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lot_occupancy_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_eg;
    int   n_xg;
    int   eg0;
    int   xg0;

    lot_occupancy_ctrl_if #(.CNT_W(3)) bus ();

    lot_occupancy_ctrl #(
        .CAPACITY (7),
        .CNT_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.enter_grant) n_eg++;
        if (bus.exit_grant)  n_xg++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request held 3 cycles, low 2; expects a grant one cycle after rising.
    task automatic pulse(input bit is_exit, input int cnt_before);
        int cnt_after;
        cnt_after = is_exit ? cnt_before - 1 : cnt_before + 1;
        if (is_exit) bus.exit_req = 1'b1; else bus.enter_req = 1'b1;
        tick();
        check_val(is_exit ? "xgrant_on" : "egrant_on",
                  is_exit ? 32'(bus.exit_grant) : 32'(bus.enter_grant), 32'd1);
        check_val("count_during_grant", 32'(bus.count), 32'(cnt_before));
        tick();
        check_val(is_exit ? "xgrant_off" : "egrant_off",
                  is_exit ? 32'(bus.exit_grant) : 32'(bus.enter_grant), 32'd0);
        check_val("count_after_grant", 32'(bus.count), 32'(cnt_after));
        tick();
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0; n_fail = 0; n_eg = 0; n_xg = 0;
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_empty", 32'(bus.empty), 32'd1);
        check_val("rst_full",  32'(bus.full),  32'd0);
        check_val("rst_egrant", 32'(bus.enter_grant), 32'd0);
        check_val("rst_xgrant", 32'(bus.exit_grant),  32'd0);
`ifdef OCC_REJECT_CNT_EN
        check_val("rst_reject", 32'(bus.reject_count), 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Three entries from empty.
        for (int i = 0; i < 3; i++) pulse(1'b0, i);
        check_val("t1_count", 32'(bus.count), 32'd3);
        check_val("t1_empty", 32'(bus.empty), 32'd0);
        check_val("t1_egrants", 32'(n_eg), 32'd3);

        // Fill to capacity, then an entry is refused.
        for (int i = 3; i < 7; i++) pulse(1'b0, i);
        check_val("t2_full", 32'(bus.full), 32'd1);
        eg0 = n_eg;
        bus.enter_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_val("t2_no_grant", 32'(n_eg - eg0), 32'd0);
        check_val("t2_count", 32'(bus.count), 32'd7);
        check_val("t2_full_hold", 32'(bus.full), 32'd1);
`ifdef OCC_REJECT_CNT_EN
        check_val("t2_reject", 32'(bus.reject_count), 32'd1);
`endif
        bus.enter_req = 1'b0;
        tick(); tick();

        // Down to 2 with exit served last, then simultaneous requests.
        for (int i = 7; i > 2; i--) pulse(1'b1, i);
        check_val("t3_count_pre", 32'(bus.count), 32'd2);
        bus.enter_req = 1'b1;
        bus.exit_req  = 1'b1;
        tick();
        check_val("t3_egrant_first", 32'(bus.enter_grant), 32'd1);
        check_val("t3_xgrant_wait",  32'(bus.exit_grant),  32'd0);
        tick();
        check_val("t3_count_up", 32'(bus.count), 32'd3);
        bus.enter_req = 1'b0;
        tick();
        check_val("t3_xgrant_not_yet", 32'(bus.exit_grant), 32'd0);
        tick();
        check_val("t3_xgrant_after", 32'(bus.exit_grant), 32'd1);
        tick();
        check_val("t3_count_down", 32'(bus.count), 32'd2);
        bus.exit_req = 1'b0;
        tick(); tick();

        // Round-robin the other way: exit was last, but now enter last -> exit first.
        pulse(1'b0, 2);
        bus.enter_req = 1'b1;
        bus.exit_req  = 1'b1;
        tick();
        check_val("t3b_xgrant_first", 32'(bus.exit_grant),  32'd1);
        check_val("t3b_egrant_wait",  32'(bus.enter_grant), 32'd0);
        tick();
        check_val("t3b_count", 32'(bus.count), 32'd2);
        bus.exit_req = 1'b0;
        tick(); tick();
        check_val("t3b_egrant_after", 32'(bus.enter_grant), 32'd1);
        tick();
        check_val("t3b_count2", 32'(bus.count), 32'd3);
        bus.enter_req = 1'b0;
        tick(); tick();

        // Empty the lot, then hold exit for 10 cycles: refused once.
        for (int i = 3; i > 0; i--) pulse(1'b1, i);
        xg0 = n_xg;
        bus.exit_req = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("t4_no_grant", 32'(n_xg - xg0), 32'd0);
        check_val("t4_empty", 32'(bus.empty), 32'd1);
        check_val("t4_count", 32'(bus.count), 32'd0);
`ifdef OCC_REJECT_CNT_EN
        check_val("t4_reject_once", 32'(bus.reject_count), 32'd2);
`endif
        bus.exit_req = 1'b0;
        tick(); tick();

        // Enter held for 20 cycles grants exactly once.
        eg0 = n_eg;
        bus.enter_req = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_val("t5_one_grant", 32'(n_eg - eg0), 32'd1);
        check_val("t5_count", 32'(bus.count), 32'd1);
        bus.enter_req = 1'b0;
        tick(); tick();

        // Reset asserted mid-grant at count 4.
        for (int i = 1; i < 4; i++) pulse(1'b0, i);
        check_val("t6_count_pre", 32'(bus.count), 32'd4);
        bus.enter_req = 1'b1;
        tick();
        check_val("t6_in_grant", 32'(bus.enter_grant), 32'd1);
        rst = 1'b1;
        #1;
        check_val("t6_rst_count",  32'(bus.count),       32'd0);
        check_val("t6_rst_egrant", 32'(bus.enter_grant), 32'd0);
        check_val("t6_rst_empty",  32'(bus.empty),       32'd1);
`ifdef OCC_REJECT_CNT_EN
        check_val("t6_rst_reject", 32'(bus.reject_count), 32'd0);
`endif
        #1;
        rst = 1'b0;
        bus.enter_req = 1'b0;
        tick();
        pulse(1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lot_occupancy_ctrl

`default_nettype wire
